// File: rtl/ex_stage_pkg.sv
// Shared constants for the execute stage: operation codes, result classes,
// enable/disable levels and the MAC accumulate FSM state encoding.
package ex_stage_pkg;

    localparam int unsigned ALUOPBUS   = 8;
    localparam int unsigned ALUSELBUS  = 3;
    localparam int unsigned REGADDRBUS = 5;

    localparam logic        RSTENABLE   = 1'b1;
    localparam logic        WRITEENABLE = 1'b1;
    localparam logic        WRITEDISABLE = 1'b0;
    localparam logic [31:0] ZEROWORD    = 32'h0;

    // Result classes
    localparam logic [2:0] EXE_RES_NOP        = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE       = 3'b011;
    localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;

    // Operation codes
    localparam logic [7:0] EXE_NOP_OP   = 8'b00000000;
    localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
    localparam logic [7:0] EXE_SLLV_OP  = 8'b00000100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
    localparam logic [7:0] EXE_SRLV_OP  = 8'b00000110;
    localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;
    localparam logic [7:0] EXE_SRAV_OP  = 8'b00000111;
    localparam logic [7:0] EXE_MOVZ_OP  = 8'b00001010;
    localparam logic [7:0] EXE_MOVN_OP  = 8'b00001011;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
    localparam logic [7:0] EXE_SLT_OP   = 8'b00101010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b00101011;
    localparam logic [7:0] EXE_ADD_OP   = 8'b00100000;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b00100001;
    localparam logic [7:0] EXE_SUB_OP   = 8'b00100010;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b00100011;
    localparam logic [7:0] EXE_ADDI_OP  = 8'b01010101;
    localparam logic [7:0] EXE_ADDIU_OP = 8'b01010110;
    localparam logic [7:0] EXE_CLZ_OP   = 8'b10110000;
    localparam logic [7:0] EXE_CLO_OP   = 8'b10110001;
    localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
    localparam logic [7:0] EXE_MUL_OP   = 8'b10101001;
    localparam logic [7:0] EXE_MADD_OP  = 8'b10100110;
    localparam logic [7:0] EXE_MADDU_OP = 8'b10101000;
    localparam logic [7:0] EXE_MSUB_OP  = 8'b10101010;
    localparam logic [7:0] EXE_MSUBU_OP = 8'b10101011;

    // MAC accumulate FSM
    typedef enum logic {
        EX_MAC_IDLE = 1'b0,
        EX_MAC_ACC  = 1'b1
    } ex_mac_state_t;

endpackage

// File: rtl/ex_mult.sv
// Combinational DATA_W x DATA_W multiplier with signed/unsigned select,
// shared by MUL, MULT/MULTU and the MAC operations.
module ex_mult #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                is_signed,
    output logic [2*DATA_W-1:0] p
);

    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;

    // Sign- or zero-extend to full width; the truncated product is then exact
    always_comb begin
        a_ext = is_signed ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
        b_ext = is_signed ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
        p     = a_ext * b_ext;
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU result mux, HI/LO forwarding and write requests, and the
// two-cycle multiply-accumulate sequence with a first-cycle stall request.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALUOPBUS-1:0]   aluop_i,
    input  logic [ALUSELBUS-1:0]  alusel_i,
    input  logic [DATA_W-1:0]     reg1_i,
    input  logic [DATA_W-1:0]     reg2_i,
    input  logic [REGADDRBUS-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [DATA_W-1:0]     hi_i,
    input  logic [DATA_W-1:0]     lo_i,
    input  logic                  mem_whilo_i,
    input  logic [DATA_W-1:0]     mem_hi_i,
    input  logic [DATA_W-1:0]     mem_lo_i,
    input  logic                  wb_whilo_i,
    input  logic [DATA_W-1:0]     wb_hi_i,
    input  logic [DATA_W-1:0]     wb_lo_i,
    output logic [REGADDRBUS-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  whilo_o,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output logic                  stallreq
);

    localparam int unsigned SHW = $clog2(DATA_W);

    ex_mac_state_t       state;
    logic [2*DATA_W-1:0] acc;

    logic [DATA_W-1:0]   fwd_hi, fwd_lo;
    logic [DATA_W-1:0]   sum;
    logic                is_sub, ov_sum, is_mac, mul_signed;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] mac_sum;
    logic [DATA_W-1:0]   logic_res, shift_res, move_res, arith_res;
    logic [DATA_W-1:0]   lead_cnt;
    logic                lead_done;

    ex_mult #(.DATA_W(DATA_W)) u_mult (
        .a         (reg1_i),
        .b         (reg2_i),
        .is_signed (mul_signed),
        .p         (prod)
    );

    // Latest HI/LO value: MEM-stage write wins over WB-stage write
    always_comb begin
        if (mem_whilo_i) begin
            fwd_hi = mem_hi_i;
            fwd_lo = mem_lo_i;
        end else if (wb_whilo_i) begin
            fwd_hi = wb_hi_i;
            fwd_lo = wb_lo_i;
        end else begin
            fwd_hi = hi_i;
            fwd_lo = lo_i;
        end
    end

    // Operation decode helpers, adder/subtractor and overflow detection
    always_comb begin
        is_mac     = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MADDU_OP) ||
                     (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
        mul_signed = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MUL_OP) ||
                     (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MSUB_OP);
        is_sub     = (aluop_i == EXE_SUB_OP) || (aluop_i == EXE_SUBU_OP);
        sum        = is_sub ? (reg1_i - reg2_i) : (reg1_i + reg2_i);
        // Sign-based overflow checked directly on operand signs so that
        // subtracting the most negative value is classified correctly
        if (is_sub)
            ov_sum = (reg1_i[DATA_W-1] != reg2_i[DATA_W-1]) &&
                     (sum[DATA_W-1] != reg1_i[DATA_W-1]);
        else
            ov_sum = (reg1_i[DATA_W-1] == reg2_i[DATA_W-1]) &&
                     (sum[DATA_W-1] != reg1_i[DATA_W-1]);
        mac_sum    = {fwd_hi, fwd_lo} + acc;
    end

    // Leading zero/one count of reg1 (CLO counts leading ones)
    always_comb begin
        lead_cnt  = '0;
        lead_done = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (!lead_done && (reg1_i[DATA_W-1-i] == (aluop_i == EXE_CLO_OP)))
                lead_cnt = lead_cnt + 1'b1;
            else
                lead_done = 1'b1;
        end
    end

    // Per-class results
    always_comb begin
        logic_res = '0;
        case (aluop_i)
            EXE_OR_OP:  logic_res = reg1_i | reg2_i;
            EXE_AND_OP: logic_res = reg1_i & reg2_i;
            EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
            default:    logic_res = '0;
        endcase

        shift_res = '0;
        case (aluop_i)
            EXE_SLL_OP, EXE_SLLV_OP: shift_res = reg2_i << reg1_i[SHW-1:0];
            EXE_SRL_OP, EXE_SRLV_OP: shift_res = reg2_i >> reg1_i[SHW-1:0];
            EXE_SRA_OP, EXE_SRAV_OP: shift_res = $signed(reg2_i) >>> reg1_i[SHW-1:0];
            default:                 shift_res = '0;
        endcase

        move_res = '0;
        case (aluop_i)
            EXE_MFHI_OP:              move_res = fwd_hi;
            EXE_MFLO_OP:              move_res = fwd_lo;
            EXE_MOVN_OP, EXE_MOVZ_OP: move_res = reg1_i;
            default:                  move_res = '0;
        endcase

        arith_res = '0;
        case (aluop_i)
            EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP,
            EXE_SUB_OP, EXE_SUBU_OP:
                arith_res = sum;
            EXE_SLT_OP:
                arith_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
            EXE_SLTU_OP:
                arith_res = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
            EXE_CLZ_OP, EXE_CLO_OP:
                arith_res = lead_cnt;
            EXE_MUL_OP:
                arith_res = prod[DATA_W-1:0];
            default:
                arith_res = '0;
        endcase
    end

    // Output mux, HI/LO write requests and MAC stall; all zero under reset
    always_comb begin
        wd_o     = '0;
        wreg_o   = 1'b0;
        wdata_o  = '0;
        whilo_o  = 1'b0;
        hi_o     = '0;
        lo_o     = '0;
        stallreq = 1'b0;
        if (rst != RSTENABLE) begin
            wd_o   = wd_i;
            wreg_o = wreg_i;
            if (((aluop_i == EXE_ADD_OP) || (aluop_i == EXE_ADDI_OP)) && ov_sum)
                wreg_o = WRITEDISABLE;

            case (alusel_i)
                EXE_RES_LOGIC:      wdata_o = logic_res;
                EXE_RES_SHIFT:      wdata_o = shift_res;
                EXE_RES_MOVE:       wdata_o = move_res;
                EXE_RES_ARITHMETIC: wdata_o = arith_res;
                default:            wdata_o = '0;
            endcase

            if (is_mac) begin
                if (state == EX_MAC_IDLE) begin
                    stallreq = 1'b1;
                end else begin
                    whilo_o       = WRITEENABLE;
                    {hi_o, lo_o}  = mac_sum;
                end
            end else begin
                case (aluop_i)
                    EXE_MTHI_OP: begin
                        whilo_o = WRITEENABLE;
                        hi_o    = reg1_i;
                        lo_o    = fwd_lo;
                    end
                    EXE_MTLO_OP: begin
                        whilo_o = WRITEENABLE;
                        hi_o    = fwd_hi;
                        lo_o    = reg1_i;
                    end
                    EXE_MULT_OP, EXE_MULTU_OP: begin
                        whilo_o      = WRITEENABLE;
                        {hi_o, lo_o} = prod;
                    end
                    default: begin
                        whilo_o = 1'b0;
                    end
                endcase
            end
        end
    end

    // MAC sequencer: capture (possibly negated) product, then release stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EX_MAC_IDLE;
            acc   <= '0;
        end else begin
            case (state)
                EX_MAC_IDLE: begin
                    if (is_mac) begin
                        if ((aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP))
                            acc <= ~prod + 1'b1;
                        else
                            acc <= prod;
                        state <= EX_MAC_ACC;
                    end
                end
                EX_MAC_ACC: begin
                    state <= EX_MAC_IDLE;
                end
                default: begin
                    state <= EX_MAC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expectations are queued as each vector is
// driven and compared when the stage output is sampled before the next edge.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] hi_i, lo_i;
    logic        mem_whilo_i, wb_whilo_i;
    logic [31:0] mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o, lo_o;
    logic        stallreq;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct {
        string       tag;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        stall;
    } exp_t;

    exp_t sb[$];

    ex_stage #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .aluop_i     (aluop_i),
        .alusel_i    (alusel_i),
        .reg1_i      (reg1_i),
        .reg2_i      (reg2_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .hi_i        (hi_i),
        .lo_i        (lo_i),
        .mem_whilo_i (mem_whilo_i),
        .mem_hi_i    (mem_hi_i),
        .mem_lo_i    (mem_lo_i),
        .wb_whilo_i  (wb_whilo_i),
        .wb_hi_i     (wb_hi_i),
        .wb_lo_i     (wb_lo_i),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .whilo_o     (whilo_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .stallreq    (stallreq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [4:0] wd, input logic wr);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = r1;
        reg2_i   = r2;
        wd_i     = wd;
        wreg_i   = wr;
    endtask

    task automatic expect_out(input string tag, input logic [4:0] wd, input logic wr,
                              input logic [31:0] wdata, input logic whilo,
                              input logic [31:0] hi, input logic [31:0] lo,
                              input logic stall);
        exp_t e;
        e.tag = tag; e.wd = wd; e.wreg = wr; e.wdata = wdata;
        e.whilo = whilo; e.hi = hi; e.lo = lo; e.stall = stall;
        sb.push_back(e);
    endtask

    task automatic sample_out();
        exp_t e;
        e = sb.pop_front();
        check_val({e.tag, ".wd"},    32'(wd_o),     32'(e.wd));
        check_val({e.tag, ".wreg"},  32'(wreg_o),   32'(e.wreg));
        check_val({e.tag, ".wdata"}, wdata_o,       e.wdata);
        check_val({e.tag, ".whilo"}, 32'(whilo_o),  32'(e.whilo));
        check_val({e.tag, ".hi"},    hi_o,          e.hi);
        check_val({e.tag, ".lo"},    lo_o,          e.lo);
        check_val({e.tag, ".stall"}, 32'(stallreq), 32'(e.stall));
    endtask

    // Sample mid-low-phase, then advance to the next falling edge
    task automatic step();
        #3;
        sample_out();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        hi_i = 32'd0; lo_i = 32'd0;
        mem_whilo_i = 1'b0; mem_hi_i = '0; mem_lo_i = '0;
        wb_whilo_i  = 1'b0; wb_hi_i  = '0; wb_lo_i  = '0;
        drive(EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'd5, 32'd6, 5'd9, 1'b1);
        expect_out("reset", 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        #3;
        sample_out();
        @(negedge clk);
        rst = 1'b0;

        // Arithmetic with overflow
        drive(EXE_ADD_OP, EXE_RES_ARITHMETIC, 32'h7FFFFFFF, 32'd1, 5'd7, 1'b1);
        expect_out("add_ov", 5'd7, 1'b0, 32'h80000000, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        drive(EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'h7FFFFFFF, 32'd1, 5'd7, 1'b1);
        expect_out("addu", 5'd7, 1'b1, 32'h80000000, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        drive(EXE_SUB_OP, EXE_RES_ARITHMETIC, 32'd5, 32'd7, 5'd3, 1'b1);
        expect_out("sub", 5'd3, 1'b1, 32'hFFFFFFFE, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        drive(EXE_SLT_OP, EXE_RES_ARITHMETIC, 32'hFFFFFFFF, 32'd1, 5'd4, 1'b1);
        expect_out("slt", 5'd4, 1'b1, 32'd1, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        drive(EXE_SLTU_OP, EXE_RES_ARITHMETIC, 32'hFFFFFFFF, 32'd1, 5'd4, 1'b1);
        expect_out("sltu", 5'd4, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        drive(EXE_CLZ_OP, EXE_RES_ARITHMETIC, 32'h0, 32'd0, 5'd2, 1'b1);
        expect_out("clz0", 5'd2, 1'b1, 32'd32, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        drive(EXE_CLZ_OP, EXE_RES_ARITHMETIC, 32'h00010000, 32'd0, 5'd2, 1'b1);
        expect_out("clz", 5'd2, 1'b1, 32'd15, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        drive(EXE_CLO_OP, EXE_RES_ARITHMETIC, 32'hFFFFFFFF, 32'd0, 5'd2, 1'b1);
        expect_out("clo1", 5'd2, 1'b1, 32'd32, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        drive(EXE_MUL_OP, EXE_RES_ARITHMETIC, 32'hFFFFFFFE, 32'd3, 5'd8, 1'b1);
        expect_out("mul", 5'd8, 1'b1, 32'hFFFFFFFA, 1'b0, 32'd0, 32'd0, 1'b0);
        step();

        // Logic and shifts
        drive(EXE_NOR_OP, EXE_RES_LOGIC, 32'h0F0F0000, 32'h000000F0, 5'd1, 1'b1);
        expect_out("nor", 5'd1, 1'b1, 32'hF0F0FF0F, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        drive(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'hF0000000, 5'd5, 1'b1);
        expect_out("sra", 5'd5, 1'b1, 32'hFF000000, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        drive(EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'hF0000000, 5'd5, 1'b1);
        expect_out("srl", 5'd5, 1'b1, 32'h0F000000, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        drive(EXE_SLL_OP, EXE_RES_SHIFT, 32'd8, 32'h00F000F1, 5'd5, 1'b1);
        expect_out("sll", 5'd5, 1'b1, 32'hF000F100, 1'b0, 32'd0, 32'd0, 1'b0);
        step();

        // HI/LO forwarding priority
        hi_i = 32'd1; wb_whilo_i = 1'b1; wb_hi_i = 32'd2;
        mem_whilo_i = 1'b1; mem_hi_i = 32'd3;
        drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd6, 1'b1);
        expect_out("mfhi_mem", 5'd6, 1'b1, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        mem_whilo_i = 1'b0;
        expect_out("mfhi_wb", 5'd6, 1'b1, 32'd2, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        wb_whilo_i = 1'b0;
        expect_out("mfhi_arch", 5'd6, 1'b1, 32'd1, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        drive(EXE_MTLO_OP, EXE_RES_NOP, 32'd55, 32'd0, 5'd0, 1'b0);
        expect_out("mtlo", 5'd0, 1'b0, 32'd0, 1'b1, 32'd1, 32'd55, 1'b0);
        step();

        // 64-bit products
        drive(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFFFFFE, 32'd3, 5'd0, 1'b0);
        expect_out("mult", 5'd0, 1'b0, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        step();
        drive(EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFFFFFE, 32'd3, 5'd0, 1'b0);
        expect_out("multu", 5'd0, 1'b0, 32'd0, 1'b1, 32'd2, 32'hFFFFFFFA, 1'b0);
        step();

        // Multiply-accumulate, held for two cycles
        hi_i = 32'd0; lo_i = 32'd10;
        drive(EXE_MADD_OP, EXE_RES_NOP, 32'd3, 32'd4, 5'd0, 1'b0);
        expect_out("madd_c1", 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        step();
        expect_out("madd_c2", 5'd0, 1'b0, 32'd0, 1'b1, 32'd0, 32'd22, 1'b0);
        step();
        drive(EXE_MSUB_OP, EXE_RES_NOP, 32'd3, 32'd4, 5'd0, 1'b0);
        expect_out("msub_c1", 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        step();
        expect_out("msub_c2", 5'd0, 1'b0, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        step();

        // Reset pulsed while the accumulate cycle is pending
        drive(EXE_MADD_OP, EXE_RES_NOP, 32'd3, 32'd4, 5'd0, 1'b0);
        expect_out("rst_c1", 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        step();
        rst = 1'b1;
        #1;
        expect_out("rst_mid", 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        sample_out();
        rst = 1'b0;
        #1;
        expect_out("rst_restart", 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        sample_out();
        @(negedge clk);
        expect_out("rst_c2", 5'd0, 1'b0, 32'd0, 1'b1, 32'd0, 32'd22, 1'b0);
        step();

        // MAC flushed after its first cycle
        drive(EXE_MADD_OP, EXE_RES_NOP, 32'd3, 32'd4, 5'd0, 1'b0);
        expect_out("flush_c1", 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        step();
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'd3, 32'd4, 5'd0, 1'b0);
        expect_out("flush_nop", 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        drive(EXE_MADD_OP, EXE_RES_NOP, 32'd3, 32'd4, 5'd0, 1'b0);
        expect_out("flush_re_c1", 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        step();
        expect_out("flush_re_c2", 5'd0, 1'b0, 32'd0, 1'b1, 32'd0, 32'd22, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the five-stage MIPS pipeline. It consumes the decoded aluop/alusel, operands, destination and write enable from the ID/EX register and produces the register write-back triple and HI/LO write requests for the EX/MEM register.
- Most operations are single-cycle combinational.
- MADD/MADDU/MSUB/MSUBU take two cycles through an internal accumulate FSM, and the stage raises stallreq during the first cycle.
- Its outputs also feed back to ID as the ex_* forwarding path.

Parameters:
- DATA_W, 32, width of register and operand words.
- (Bus widths otherwise come from the shared include: ALUOPBUS 8 bits, ALUSELBUS 3 bits, REGADDRBUS 5 bits.)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, active-high, asynchronous
- aluop_i  in  8  operation code (EXE_*_OP)
- alusel_i  in  3  result class (EXE_RES_*)
- reg1_i  in  32  operand 1 (rs, or sa/imm from ID)
- reg2_i  in  32  operand 2 (rt or imm)
- wd_i  in  5  destination register
- wreg_i  in  1  register write enable
- hi_i, lo_i  in  32 each  architectural HI/LO
- mem_whilo_i, mem_hi_i, mem_lo_i  in  1/32/32  HI/LO write in MEM stage
- wb_whilo_i, wb_hi_i, wb_lo_i  in  1/32/32  HI/LO write in WB stage
- wd_o  out  5  destination
- wreg_o  out  1  write enable
- wdata_o  out  32  result
- whilo_o  out  1  HI/LO write enable
- hi_o, lo_o  out  32 each  HI/LO values to write
- stallreq  out  1  stall request to pipeline control

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values (rst=1): every output is 0, state=IDLE, acc=64'h0.
- Pass-through: wd_o=wd_i.
- wreg_o=wreg_i, except on ADD/ADDI signed overflow, where wreg_o=0 (result is discarded).
- HI/LO operand: if mem_whilo_i, use mem_hi_i/mem_lo_i; else if wb_whilo_i, use wb_*; else use hi_i/lo_i. MEM has priority over WB.
- Result mux on alusel_i:
  - LOGIC: OR/AND/XOR/NOR of reg1, reg2.
  - SHIFT: reg2 shifted by reg1[4:0]. SLL is left logical; SRL is right logical; SRA and SRAV are right arithmetic.
  - MOVE: MFHI gives fwd HI; MFLO gives fwd LO; MOVN/MOVZ give reg1.
  - ARITH:
    - ADD/ADDU/SUB/SUBU are 32-bit wrap-around.
    - SLT is a signed compare; SLTU is an unsigned compare. The result is 0 or 1.
    - CLZ/CLO count leading zeros/ones of reg1, giving 32 if the word is all zeros/ones.
    - MUL gives the low 32 bits of the signed product.
  - NOP or unknown: 0.
- Overflow: ADD overflows when both operands have the same sign and the sum has the opposite sign. SUB overflows when the operands have different signs and the result sign differs from reg1.
- HI/LO writes:
  - MTHI: whilo=1, hi_o=reg1, lo_o=fwd LO.
  - MTLO: whilo=1, hi_o=fwd HI, lo_o=reg1.
  - MULT/MULTU: whilo=1, {hi_o,lo_o} = 64-bit signed/unsigned product of reg1 and reg2.
  - All other ops: whilo=0 and hi_o/lo_o=0.
- MAC FSM, state register plus 64-bit acc register:
  - IDLE, and aluop_i is a MAC op: acc <= product (signed for MADD/MSUB, unsigned for MADDU/MSUBU); MSUB/MSUBU store the two's-complement negated product. stallreq=1, whilo_o=0. Next state ACC.
  - ACC, and aluop_i is a MAC op: {hi_o,lo_o} = {fwd HI, fwd LO} + acc (64-bit wrap), whilo_o=1, stallreq=0. Next state IDLE.
  - ACC, and aluop_i is not a MAC op (instruction flushed): no write, stallreq=0. Next state IDLE.
  - IDLE, non-MAC op: stay in IDLE.
- Latency:
  - MAC ops: 2 cycles, 1 stall cycle. ID/EX holds the instruction during the stall.
  - Back-to-back MACs: each one takes IDLE->ACC->IDLE, with no overlap.
  - All other ops: 0-cycle combinational.
- Reset asserted in ACC: state goes to IDLE immediately, and no HI/LO write is emitted.

Decomposition:
- All EXE_*_OP, EXE_RES_* and enable/disable constants (WRITEENABLE, RSTENABLE, ZEROWORD) live in the shared macro.v include.
- Add the FSM state constants EX_MAC_IDLE and EX_MAC_ACC there.
- One natural sub-module: ex_mult, a combinational 32x32 multiplier with a signed/unsigned select. It is shared by MUL, MULT/MULTU and the MAC ops.

Test Plan:
- ADD reg1=32'h7FFFFFFF, reg2=1, wreg_i=1 -> wdata_o=32'h80000000, wreg_o=0. ADDU with the same operands -> wreg_o=1.
- SRA reg1=4, reg2=32'hF0000000 -> wdata_o=32'hFF000000. SRL with the same operands -> 32'h0F000000.
- MFHI with hi_i=1, wb_whilo_i=1 (wb_hi_i=2), mem_whilo_i=1 (mem_hi_i=3) -> wdata_o=3. Drop mem_whilo_i -> wdata_o=2.
- MULT reg1=32'hFFFFFFFE (-2), reg2=3 -> whilo_o=1, hi_o=32'hFFFFFFFF, lo_o=32'hFFFFFFFA. MULTU with the same operands -> hi_o=2, lo_o=32'hFFFFFFFA.
- MADD held 2 cycles, HI/LO=0/10, reg1=3, reg2=4 -> cycle 1: stallreq=1, whilo_o=0. Cycle 2: stallreq=0, whilo_o=1, lo_o=22, hi_o=0. MSUB with the same inputs -> lo_o=32'hFFFFFFFE, hi_o=32'hFFFFFFFF.
- MADD cycle 1, then rst pulsed asynchronously mid-cycle, then MADD re-presented -> stallreq=1 again, since the FSM restarted in IDLE. Also: MADD cycle 1 followed by a NOP -> whilo_o=0 and the FSM returns to IDLE.
